onchip_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port 6000 x 32 on-chip RAM in the Nios subsystem. Port 0 serves the Nios data master. Port 1 serves the SDR sample/DMA engine. The block grants one transfer per cycle using round-robin, drives the RAM's single address/data port, and returns read data with a one-cycle `readdatavalid` pulse to the requester that issued the read. Out-of-range accesses are blocked from the RAM and flagged.

---
 rtl/onchip_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin two-master front end for the shared
// single-port on-chip RAM, with 1-cycle read return and range checking.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 6000
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  output logic                  m0_err,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  m1_err,

  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic req0;
  logic req1;
  logic in0;
  logic in1;
  logic grant0;
  logic grant1;
  logic last_grant;
  logic rv0;
  logic rv1;
  logic oor;
  logic err0;
  logic err1;
  logic [DATA_W-1:0] rdata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign in0 = {1'b0, m0_address} < LIMIT;
  assign in1 = {1'b0, m1_address} < LIMIT;

  // Contention goes to the port that did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        req0 & req1: begin
          grant0 = last_grant;
          grant1 = ~last_grant;
        end
        req0 & ~req1: grant0 = 1'b1;
        ~req0 & req1: grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  always_comb begin
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    unique case (1'b1)
      grant0: begin
        ram_chipselect = in0;
        ram_write      = in0 & m0_write;
      end
      grant1: begin
        ram_chipselect = in1;
        ram_write      = in1 & m1_write;
        ram_address    = m1_address;
        ram_byteenable = m1_byteenable;
        ram_writedata  = m1_writedata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rv0        <= 1'b0;
      rv1        <= 1'b0;
      oor        <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
      rv0  <= grant0 & m0_read & ~m0_write;
      rv1  <= grant1 & m1_read & ~m1_write;
      oor  <= (grant0 & ~in0) | (grant1 & ~in1);
      err0 <= err0 | (grant0 & ~in0);
      err1 <= err1 | (grant1 & ~in1);
    end
  end

  // While reset is held, return-path state reads as cleared at once.
  assign m0_readdatavalid = rv0 & ~reset;
  assign m1_readdatavalid = rv1 & ~reset;
  assign m0_err           = err0 & ~reset;
  assign m1_err           = err1 & ~reset;

  assign rdata       = oor ? '0 : ram_readdata;
  assign m0_readdata = rdata;
  assign m1_readdata = rdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: RAM model plus behavioural reference checked
// every cycle, with directed literal pins and randomized traffic.
module tb_onchip_mem_arbiter;

  localparam int DEPTH = 6000;

  logic clk = 1'b0;
  logic reset;
  logic [12:0] m0_address;
  logic [12:0] m1_address;
  logic [3:0]  m0_byteenable;
  logic [3:0]  m1_byteenable;
  logic        m0_read;
  logic        m0_write;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m0_writedata;
  logic [31:0] m1_writedata;
  logic        m0_waitrequest;
  logic        m1_waitrequest;
  logic [31:0] m0_readdata;
  logic [31:0] m1_readdata;
  logic        m0_readdatavalid;
  logic        m1_readdatavalid;
  logic        m0_err;
  logic        m1_err;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  logic [31:0] mem [0:DEPTH-1];
  logic [12:0] addr_q;
  bit          ram_init = 1'b0;

  logic [31:0] ref_mem [0:DEPTH-1];
  bit          ref_init = 1'b0;

  int total = 0;
  int bad = 0;
  int glog[$];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int cs_count = 0;
  int req_id = 0;
  int done_id = 0;
  int mk_g = 0;
  int mk_q0 = 0;
  int mk_q1 = 0;
  int mk_cs = 0;

  int          m_last = 1;
  bit          m_rv0 = 1'b0;
  bit          m_rv1 = 1'b0;
  bit          m_err0 = 1'b0;
  bit          m_err1 = 1'b0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_err           (m0_err),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_err           (m1_err),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_readdata     (ram_readdata)
  );

  // Single-port RAM: registered address, unregistered read data.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      addr_q   <= '0;
      ram_init <= 1'b1;
    end else if (ram_chipselect) begin
      addr_q <= ram_address;
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    end
  end

  assign ram_readdata = mem[addr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic int gat(input int idx);
    if (idx >= 0 && idx < glog.size()) return glog[idx];
    return -9;
  endfunction

  function automatic logic [31:0] qat0(input int idx);
    if (idx >= 0 && idx < q0.size()) return q0[idx];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qat1(input int idx);
    if (idx >= 0 && idx < q1.size()) return q1[idx];
    return 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk) begin : cmp
    int gp;
    bit r0, r1, o0, o1, g0, g1, rd, wr, oo, ecs, ewe;
    logic [12:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    int alt [6];
    alt = '{0, 1, 0, 1, 0, 1};
    if (!ref_init) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_init = 1'b1;
    end

    r0 = m0_read || m0_write;
    r1 = m1_read || m1_write;
    o0 = int'(m0_address) >= DEPTH;
    o1 = int'(m1_address) >= DEPTH;
    gp = -1;
    if (!reset) begin
      if (r0 && r1) gp = 1 - m_last;
      else if (r0) gp = 0;
      else if (r1) gp = 1;
    end
    g0  = (gp == 0);
    g1  = (gp == 1);
    rd  = g1 ? m1_read : m0_read;
    wr  = g1 ? m1_write : m0_write;
    a   = g1 ? m1_address : m0_address;
    be  = g1 ? m1_byteenable : m0_byteenable;
    d   = g1 ? m1_writedata : m0_writedata;
    oo  = g1 ? o1 : o0;
    ecs = (gp >= 0) && !oo;
    ewe = ecs && wr;

    chk1("wait0", m0_waitrequest, !g0);
    chk1("wait1", m1_waitrequest, !g1);
    chk1("ram_cs", ram_chipselect, ecs);
    chk1("ram_we", ram_write, ewe);
    if (ecs) chk("ram_addr", 32'(ram_address), 32'(a));
    if (ewe) begin
      chk("ram_be", 32'(ram_byteenable), 32'(be));
      chk("ram_wdata", ram_writedata, d);
    end
    chk1("rdv0", m0_readdatavalid, m_rv0 && !reset);
    chk1("rdv1", m1_readdatavalid, m_rv1 && !reset);
    if (m_rv0 && !reset) chk("rdata0", m0_readdata, m_rdata);
    if (m_rv1 && !reset) chk("rdata1", m1_readdata, m_rdata);
    chk1("err0", m0_err, m_err0 && !reset);
    chk1("err1", m1_err, m_err1 && !reset);

    if (!m0_waitrequest && !m1_waitrequest) glog.push_back(2);
    else if (!m0_waitrequest) glog.push_back(0);
    else if (!m1_waitrequest) glog.push_back(1);
    else glog.push_back(-1);
    if (m0_readdatavalid) q0.push_back(m0_readdata);
    if (m1_readdatavalid) q1.push_back(m1_readdata);
    if (ram_chipselect) cs_count++;

    if (req_id != done_id) begin
      case (req_id)
        1: begin
          chk1("rst_wait0", m0_waitrequest, 1'b1);
          chk1("rst_wait1", m1_waitrequest, 1'b1);
          chk1("rst_err0", m0_err, 1'b0);
          chk1("rst_err1", m1_err, 1'b0);
          chk1("rst_rdv0", m0_readdatavalid, 1'b0);
        end
        2: begin
          chk("uc_grant_w", 32'(gat(mk_g)), 32'd0);
          chk("uc_grant_r", 32'(gat(mk_g + 1)), 32'd0);
          chk("uc_nvalid", 32'(q0.size() - mk_q0), 32'd1);
          chk("uc_data", qat0(mk_q0), 32'hA5A5_1234);
        end
        3: chk("bytes_data", qat0(mk_q0), 32'hFF00_FF00);
        4: begin
          for (int i = 0; i < 6; i++) chk("alt_grant", 32'(gat(mk_g + i)), 32'(alt[i]));
          chk("alt_n0", 32'(q0.size() - mk_q0), 32'd3);
          chk("alt_n1", 32'(q1.size() - mk_q1), 32'd3);
          for (int i = 0; i < 3; i++) begin
            chk("alt_d0", qat0(mk_q0 + i), 32'h1111_1111);
            chk("alt_d1", qat1(mk_q1 + i), 32'h2222_2222);
          end
        end
        5: begin
          chk("oor_cs", 32'(cs_count - mk_cs), 32'd0);
          chk("oor_nvalid", 32'(q1.size() - mk_q1), 32'd1);
          chk("oor_data", qat1(mk_q1), 32'h0);
          chk1("oor_err1", m1_err, 1'b1);
          chk1("oor_err0", m0_err, 1'b0);
        end
        6: chk1("oor_err1_sticky", m1_err, 1'b1);
        7: begin
          chk("rstmid_grant", 32'(gat(glog.size() - 1)), 32'd0);
          chk("rstmid_nvalid", 32'(q0.size() - mk_q0), 32'd0);
          chk1("rstmid_err0", m0_err, 1'b0);
          chk1("rstmid_err1", m1_err, 1'b0);
        end
        8: begin
          chk("raw_grant_w", 32'(gat(mk_g)), 32'd1);
          chk("raw_grant_r", 32'(gat(mk_g + 1)), 32'd0);
          chk("raw_data", qat0(q0.size() - 1), 32'h5555_AAAA);
        end
        default: ;
      endcase
      done_id = req_id;
    end

    if (reset) begin
      m_last = 1;
      m_rv0  = 1'b0;
      m_rv1  = 1'b0;
      m_err0 = 1'b0;
      m_err1 = 1'b0;
    end else begin
      m_rv0 = g0 && rd && !wr;
      m_rv1 = g1 && rd && !wr;
      if (gp >= 0) begin
        m_last  = gp;
        m_rdata = oo ? 32'h0 : ref_mem[a];
        if (wr && !oo)
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        if (oo && g0) m_err0 = 1'b1;
        if (oo && g1) m_err1 = 1'b1;
      end
    end
  end

  task automatic drive(input bit rst,
                       input bit rd0, input bit wr0, input int a0,
                       input logic [3:0] be0, input logic [31:0] d0,
                       input bit rd1, input bit wr1, input int a1,
                       input logic [3:0] be1, input logic [31:0] d1);
    reset         = rst;
    m0_read       = rd0;
    m0_write      = wr0;
    m0_address    = 13'(a0);
    m0_byteenable = be0;
    m0_writedata  = d0;
    m1_read       = rd1;
    m1_write      = wr1;
    m1_address    = 13'(a1);
    m1_byteenable = be1;
    m1_writedata  = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rst);
    drive(rst, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic mark();
    mk_g  = glog.size();
    mk_q0 = q0.size();
    mk_q1 = q1.size();
    mk_cs = cs_count;
  endtask

  function automatic int rand_addr();
    case ($urandom_range(0, 9))
      0: return int'($urandom_range(5990, 6010));
      1: return int'($urandom_range(6000, 8191));
      2: return int'($urandom_range(0, DEPTH - 1));
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    repeat (3) idle(1);
    req_id = 1;
    idle(0);

    mark();
    drive(0, 0, 1, 'h10, 4'hF, 32'hA5A5_1234, 0, 0, 0, 4'h0, 32'h0);
    drive(0, 1, 0, 'h10, 4'hF, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    req_id = 2;
    idle(0);

    mark();
    drive(0, 0, 1, 'h20, 4'hF, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0);
    drive(0, 0, 1, 'h20, 4'h5, 32'h0000_0000, 0, 0, 0, 4'h0, 32'h0);
    drive(0, 1, 0, 'h20, 4'hF, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    req_id = 3;
    idle(0);

    drive(0, 0, 1, 1, 4'hF, 32'h1111_1111, 0, 0, 0, 4'h0, 32'h0);
    drive(0, 0, 0, 0, 4'h0, 32'h0, 0, 1, 2, 4'hF, 32'h2222_2222);
    mark();
    repeat (6) drive(0, 1, 0, 1, 4'hF, 32'h0, 1, 0, 2, 4'hF, 32'h0);
    req_id = 4;
    idle(0);

    mark();
    drive(0, 0, 0, 0, 4'h0, 32'h0, 0, 1, 6000, 4'hF, 32'hCAFE_F00D);
    drive(0, 0, 0, 0, 4'h0, 32'h0, 1, 0, 6100, 4'hF, 32'h0);
    req_id = 5;
    idle(0);
    req_id = 6;
    idle(0);

    mark();
    drive(0, 1, 0, 'h10, 4'hF, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    idle(1);
    drive(1, 1, 0, 'h10, 4'hF, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    req_id = 7;
    drive(0, 1, 0, 1, 4'hF, 32'h0, 1, 0, 2, 4'hF, 32'h0);
    idle(0);

    drive(0, 1, 0, 0, 4'hF, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    mark();
    drive(0, 1, 0, 'h100, 4'hF, 32'h0, 0, 1, 'h100, 4'hF, 32'h5555_AAAA);
    drive(0, 1, 0, 'h100, 4'hF, 32'h0, 0, 0, 0, 4'h0, 32'h0);
    req_id = 8;
    idle(0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 149) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
            4'($urandom), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
            4'($urandom), $urandom);
    end
    idle(0);
    idle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
